// File: rtl/i2c_slave_if.sv
// Application-side handshake of the I2C slave: read data request/return,
// received write data, and status. The I2C pins themselves stay plain ports.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       nack_rcvd;
  logic [2:0] debug_state;

  modport master (
    output tx_data,
    input  tx_req, rx_data, rx_valid, busy, nack_rcvd, debug_state
  );

  modport slave (
    input  tx_data,
    output tx_req, rx_data, rx_valid, busy, nack_rcvd, debug_state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C slave (7-bit address), oversampled on clk with no scl-clocked logic.
// sda is open-drain: driven low or released, never driven high.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scl,
  inout  wire          sda,
  i2c_slave_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  state_t     state, state_nx;
  logic [1:0] scl_s, sda_s;
  logic       scl_d, sda_d;
  logic [6:0] shreg, shreg_nx;
  logic [2:0] cnt, cnt_nx;
  logic       oe, oe_nx;
  logic       busy, busy_nx;
  logic       rw, rw_nx;
  logic       acked, acked_nx;
  logic [6:0] tx_sh, tx_sh_nx;
  logic [7:0] rx_q, rx_nx;
  logic       rx_v, rx_v_nx;
  logic       txr, txr_nx;
  logic       nack, nack_nx;

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;

  assign scl_rise = scl_s[1] & ~scl_d;
  assign scl_fall = ~scl_s[1] & scl_d;
  // Bus conditions are ignored while we pull sda ourselves.
  assign start_c  = ~oe & scl_s[1] & scl_d & sda_d & ~sda_s[1];
  assign stop_c   = ~oe & scl_s[1] & scl_d & ~sda_d & sda_s[1];
  assign byte_in  = {shreg, sda_s[1]};

  assign sda             = oe ? 1'b0 : 1'bz;
  assign bus.tx_req      = txr;
  assign bus.rx_data     = rx_q;
  assign bus.rx_valid    = rx_v;
  assign bus.busy        = busy;
  assign bus.nack_rcvd   = nack;
  assign bus.debug_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s <= '1;
      sda_s <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      oe    <= 1'b0;
      busy  <= 1'b0;
      rw    <= 1'b0;
      acked <= 1'b0;
      tx_sh <= '0;
      rx_q  <= '0;
      rx_v  <= 1'b0;
      txr   <= 1'b0;
      nack  <= 1'b0;
    end else begin
      scl_s <= {scl_s[0], scl};
      sda_s <= {sda_s[0], sda};
      scl_d <= scl_s[1];
      sda_d <= sda_s[1];
      state <= state_nx;
      shreg <= shreg_nx;
      cnt   <= cnt_nx;
      oe    <= oe_nx;
      busy  <= busy_nx;
      rw    <= rw_nx;
      acked <= acked_nx;
      tx_sh <= tx_sh_nx;
      rx_q  <= rx_nx;
      rx_v  <= rx_v_nx;
      txr   <= txr_nx;
      nack  <= nack_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    oe_nx    = oe;
    busy_nx  = busy;
    rw_nx    = rw;
    acked_nx = acked;
    tx_sh_nx = tx_sh;
    rx_nx    = rx_q;
    rx_v_nx  = 1'b0;
    txr_nx   = 1'b0;
    nack_nx  = 1'b0;

    if (start_c) begin
      state_nx = ADDR;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
      acked_nx = 1'b0;
    end else if (stop_c) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      oe_nx    = 1'b0;
      busy_nx  = 1'b0;
      acked_nx = 1'b0;
    end else begin
      case (state)
        IDLE: oe_nx = 1'b0;

        ADDR: if (scl_rise) begin
          shreg_nx = byte_in[6:0];
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (byte_in[7:1] == SLAVE_ADDR) begin
              state_nx = ADDR_ACK;
              busy_nx  = 1'b1;
              rw_nx    = byte_in[0];
            end else begin
              state_nx = IDLE;
            end
          end
        end

        // First falling edge starts the ACK pulse, the second one ends it.
        ADDR_ACK, WR_ACK: if (scl_fall) begin
          if (!oe) begin
            oe_nx = 1'b1;
          end else begin
            oe_nx  = 1'b0;
            cnt_nx = '0;
            if (state == WR_ACK || !rw) begin
              state_nx = WR_DATA;
            end else begin
              state_nx = RD_DATA;
              txr_nx   = 1'b1;
              tx_sh_nx = bus.tx_data[6:0];
              oe_nx    = ~bus.tx_data[7];
            end
          end
        end

        WR_DATA: if (scl_rise) begin
          shreg_nx = byte_in[6:0];
          cnt_nx   = cnt + 3'd1;
          if (cnt == 3'd7) begin
            rx_nx    = byte_in;
            rx_v_nx  = 1'b1;
            state_nx = WR_ACK;
          end
        end

        RD_DATA: if (scl_fall) begin
          if (cnt == 3'd7) begin
            oe_nx    = 1'b0;
            cnt_nx   = '0;
            acked_nx = 1'b0;
            state_nx = RD_ACK;
          end else begin
            oe_nx    = ~tx_sh[6];
            tx_sh_nx = {tx_sh[5:0], 1'b0};
            cnt_nx   = cnt + 3'd1;
          end
        end

        RD_ACK: begin
          if (scl_rise && !acked) begin
            if (sda_s[1]) begin
              nack_nx  = 1'b1;
              busy_nx  = 1'b0;
              state_nx = IDLE;
            end else begin
              acked_nx = 1'b1;
            end
          end else if (scl_fall && acked) begin
            acked_nx = 1'b0;
            state_nx = RD_DATA;
            cnt_nx   = '0;
            txr_nx   = 1'b1;
            tx_sh_nx = bus.tx_data[6:0];
            oe_nx    = ~bus.tx_data[7];
          end
        end

        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
